// File: rtl/pll_reconfig_ctrl.sv
// pll_reconfig_ctrl
//   Runtime reconfiguration and lock supervisor for a GPLL wrapper.
//   On request it writes the feedback divider and NCH channel dividers over
//   APB while holding the PLL in reset. It then releases reset, qualifies the
//   synchronised lock and reports done or error. While running it filters lock
//   loss and, when AUTO_RELOCK is set, pulses the PLL reset to re-acquire lock.
//
// Ports
//   clk, rst_n              controller/APB clock, async active-low reset
//   cfg_req                 one-cycle reprogram request (IDLE/RUN/ERROR only)
//   cfg_ratiom, cfg_ratio   feedback divider, packed channel dividers (8b each)
//   cfg_busy/done/err       request status; err_code 01=lock tmo, 10=APB tmo
//   pll_lock, pll_rst       raw async lock in, PLL reset out (active high)
//   locked, lock_lost       qualified lock, one-cycle lock loss pulse
//   apb_*                   APB write master (sel/en/write/addr/wdata/ready)

module pll_reconfig_ctrl #(
  parameter int         NCH         = 1,
  parameter logic [4:0] M_ADDR      = 5'd0,
  parameter logic [4:0] CH_BASE     = 5'd1,
  parameter int         RST_CYC     = 16,
  parameter int         LOCK_STABLE = 256,
  parameter int         LOSS_FILT   = 4,
  parameter int         TIMEOUT     = 65536,
  parameter int         AUTO_RELOCK = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_req,
  input  logic [6:0]       cfg_ratiom,
  input  logic [8*NCH-1:0] cfg_ratio,
  output logic             cfg_busy,
  output logic             cfg_done,
  output logic             cfg_err,
  output logic [1:0]       err_code,
  input  logic             pll_lock,
  output logic             pll_rst,
  output logic             locked,
  output logic             lock_lost,
  output logic [4:0]       apb_addr,
  output logic             apb_sel,
  output logic             apb_en,
  output logic             apb_write,
  output logic [15:0]      apb_wdata,
  input  logic             apb_ready
);

  localparam int KW = $clog2(NCH + 1);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam int SW = $clog2(LOCK_STABLE) + 1;
  localparam int HW = $clog2(RST_CYC) + 1;
  localparam int LW = $clog2(LOSS_FILT) + 1;

  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(LOCK_STABLE - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_CYC - 1);
  localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_FILT - 1);
  localparam logic [KW-1:0] K_LAST    = KW'(NCH);

  typedef enum logic [2:0] {
    IDLE, WR_SETUP, WR_ACCESS, HOLD_RST, WAIT_LOCK, RUN, ERROR
  } state_t;

  state_t state;

  logic lock_s1, lock_s2;

  logic [NCH-1:0][7:0] ratio_in, ratio_clamp, ratio_q;
  logic [6:0]          ratiom_eff;
  logic [7:0]          ch_next;
  logic [KW-1:0]       k_q;

  logic [TW-1:0] tmo_cnt;
  logic [SW-1:0] stab_cnt;
  logic [HW-1:0] hold_cnt;
  logic [LW-1:0] loss_cnt;

  logic accept, loss_hit;

  // Raw lock is asynchronous; only lock_s2 is used below.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_s1 <= 1'b0;
      lock_s2 <= 1'b0;
    end else begin
      lock_s1 <= pll_lock;
      lock_s2 <= lock_s1;
    end
  end

  // A zero divider is illegal in the PLL; it is programmed as 1.
  assign ratio_in   = cfg_ratio;
  assign ratiom_eff = (cfg_ratiom == 7'd0) ? 7'd1 : cfg_ratiom;

  for (genvar i = 0; i < NCH; i++) begin : g_clamp
    assign ratio_clamp[i] = (ratio_in[i] == 8'd0) ? 8'd1 : ratio_in[i];
  end

  // Channel k is written as word k+1, so ch_next is the next word's payload.
  always_comb begin
    ch_next = 8'd1;
    for (int i = 0; i < NCH; i++)
      if (k_q == KW'(i)) ch_next = ratio_q[i];
  end

  assign accept   = cfg_req && (state == IDLE || state == RUN || state == ERROR);
  assign loss_hit = (state == RUN) && !lock_s2 && (loss_cnt == LOSS_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT_LOCK;
      ratio_q   <= '0;
      k_q       <= '0;
      tmo_cnt   <= '0;
      stab_cnt  <= '0;
      hold_cnt  <= '0;
      loss_cnt  <= '0;
      cfg_busy  <= 1'b0;
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
      err_code  <= 2'b00;
      pll_rst   <= 1'b0;
      locked    <= 1'b0;
      lock_lost <= 1'b0;
      apb_addr  <= '0;
      apb_sel   <= 1'b0;
      apb_en    <= 1'b0;
      apb_write <= 1'b0;
      apb_wdata <= '0;
    end else begin
      cfg_done  <= 1'b0;
      lock_lost <= 1'b0;

      // Lock loss is reported even when a same-cycle request takes priority.
      if (loss_hit) begin
        lock_lost <= 1'b1;
        locked    <= 1'b0;
      end

      if (accept) begin
        ratio_q   <= ratio_clamp;
        k_q       <= '0;
        loss_cnt  <= '0;
        pll_rst   <= 1'b1;
        cfg_busy  <= 1'b1;
        locked    <= 1'b0;
        cfg_err   <= 1'b0;
        err_code  <= 2'b00;
        apb_sel   <= 1'b1;
        apb_en    <= 1'b0;
        apb_write <= 1'b1;
        apb_addr  <= M_ADDR;
        apb_wdata <= {9'd0, ratiom_eff};
        state     <= WR_SETUP;
      end else begin
        case (state)
          WR_SETUP: begin
            apb_en  <= 1'b1;
            tmo_cnt <= '0;
            state   <= WR_ACCESS;
          end

          WR_ACCESS: begin
            if (apb_ready) begin
              apb_en <= 1'b0;
              if (k_q < K_LAST) begin
                k_q       <= k_q + 1'b1;
                apb_addr  <= CH_BASE + 5'(k_q);
                apb_wdata <= {8'd0, ch_next};
                state     <= WR_SETUP;
              end else begin
                apb_sel   <= 1'b0;
                apb_write <= 1'b0;
                hold_cnt  <= '0;
                state     <= HOLD_RST;
              end
            end else if (tmo_cnt == TMO_LAST) begin
              // PLL is left in reset: its divider state is half-written.
              apb_sel   <= 1'b0;
              apb_en    <= 1'b0;
              apb_write <= 1'b0;
              cfg_err   <= 1'b1;
              err_code  <= 2'b10;
              cfg_busy  <= 1'b0;
              state     <= ERROR;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end

          HOLD_RST: begin
            if (hold_cnt == HOLD_LAST) begin
              pll_rst  <= 1'b0;
              stab_cnt <= '0;
              tmo_cnt  <= '0;
              state    <= WAIT_LOCK;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end

          WAIT_LOCK: begin
            if (lock_s2 && stab_cnt == STAB_LAST) begin
              locked   <= 1'b1;
              loss_cnt <= '0;
              state    <= RUN;
              if (cfg_busy) begin
                cfg_done <= 1'b1;
                cfg_busy <= 1'b0;
              end
            end else if (tmo_cnt == TMO_LAST) begin
              cfg_err  <= 1'b1;
              err_code <= 2'b01;
              cfg_busy <= 1'b0;
              state    <= ERROR;
            end else begin
              tmo_cnt  <= tmo_cnt + 1'b1;
              stab_cnt <= lock_s2 ? stab_cnt + 1'b1 : '0;
            end
          end

          RUN: begin
            if (loss_hit) begin
              loss_cnt <= '0;
              if (AUTO_RELOCK != 0) begin
                pll_rst  <= 1'b1;
                hold_cnt <= '0;
                state    <= HOLD_RST;
              end else begin
                stab_cnt <= '0;
                tmo_cnt  <= '0;
                state    <= WAIT_LOCK;
              end
            end else if (!lock_s2) begin
              loss_cnt <= loss_cnt + 1'b1;
            end else begin
              loss_cnt <= '0;
            end
          end

          default: ; // IDLE and ERROR hold until a request
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Self-checking bench for pll_reconfig_ctrl: random reprogram requests checked
// against a write-list / latency model, plus timeouts, lock filtering and reset.
module tb_pll_reconfig_ctrl;

  localparam int         NCH         = 3;
  localparam int         RST_CYC     = 16;
  localparam int         LOCK_STABLE = 256;
  localparam int         LOSS_FILT   = 4;
  localparam int         TIMEOUT     = 1024;
  localparam logic [4:0] M_ADDR      = 5'd0;
  localparam logic [4:0] CH_BASE     = 5'd1;

  logic             clk = 1'b0, rst_n = 1'b0, cfg_req = 1'b0;
  logic [6:0]       cfg_ratiom = '0;
  logic [8*NCH-1:0] cfg_ratio = '0;
  logic             cfg_busy, cfg_done, cfg_err, pll_rst, locked, lock_lost;
  logic [1:0]       err_code;
  logic             pll_lock = 1'b0;
  logic [4:0]       apb_addr;
  logic             apb_sel, apb_en, apb_write;
  logic [15:0]      apb_wdata;
  logic             apb_ready;

  pll_reconfig_ctrl #(
    .NCH(NCH), .M_ADDR(M_ADDR), .CH_BASE(CH_BASE), .RST_CYC(RST_CYC),
    .LOCK_STABLE(LOCK_STABLE), .LOSS_FILT(LOSS_FILT), .TIMEOUT(TIMEOUT),
    .AUTO_RELOCK(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_req(cfg_req), .cfg_ratiom(cfg_ratiom),
    .cfg_ratio(cfg_ratio), .cfg_busy(cfg_busy), .cfg_done(cfg_done),
    .cfg_err(cfg_err), .err_code(err_code), .pll_lock(pll_lock),
    .pll_rst(pll_rst), .locked(locked), .lock_lost(lock_lost),
    .apb_addr(apb_addr), .apb_sel(apb_sel), .apb_en(apb_en),
    .apb_write(apb_write), .apb_wdata(apb_wdata), .apb_ready(apb_ready)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  int done_cnt = 0, lost_cnt = 0;
  int wcnt = 0, last_wr_cyc = 0;
  int dly_tab[8];
  bit stuck = 1'b0;
  logic [20:0] exp_q[$];
  logic [20:0] w;
  logic [4:0]  su_addr;
  logic [15:0] su_data;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // Model: the ordered list of APB writes a request must produce.
  task automatic push_model(input logic [6:0] rm, input logic [8*NCH-1:0] r);
    int d;
    d = (rm == 0) ? 1 : int'(rm);
    exp_q.push_back({M_ADDR, 16'(d)});
    for (int i = 0; i < NCH; i++) begin
      d = int'(r[8*i +: 8]);
      if (d == 0) d = 1;
      exp_q.push_back({5'(int'(CH_BASE) + i), 16'(d)});
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_ctl"}, {pll_rst, locked, cfg_busy, cfg_done, cfg_err, err_code,
                        lock_lost, apb_sel, apb_en, apb_write}, 0);
    chk({tag, "_addr"}, apb_addr, 0);
    chk({tag, "_wdata"}, apb_wdata, 0);
  endtask

  // APB slave: ready after dly_tab[word] extra access cycles.
  initial begin
    int acc;
    acc = 0;
    apb_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (apb_sel && apb_en && !stuck) begin
        apb_ready = (acc >= ((wcnt < 8) ? dly_tab[wcnt] : 0));
        acc++;
      end else begin
        apb_ready = 1'b0;
        acc = 0;
      end
    end
  end

  // Monitor: write ordering/content, setup-to-ready stability, pulse counts.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("write_only_with_sel", apb_write & ~apb_sel, 0);
      if (cfg_done) done_cnt++;
      if (lock_lost) lost_cnt++;
      if (apb_sel && !apb_en) begin
        su_addr = apb_addr;
        su_data = apb_wdata;
      end
      if (apb_sel && apb_en && apb_ready) begin
        chk("apb_addr_stable", apb_addr, su_addr);
        chk("apb_data_stable", apb_wdata, su_data);
        chk("apb_write_hi", apb_write, 1);
        chk("apb_word_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          chk("apb_addr", apb_addr, w[20:16]);
          chk("apb_data", apb_wdata, w[15:0]);
        end
        wcnt++;
        last_wr_cyc = cyc;
      end
    end
  end

  task automatic do_cfg(input logic [6:0] rm, input logic [8*NCH-1:0] r,
                        input bit lock_ok, input bit poke);
    int t0, tf, t1, n, sum, d0;
    sum = 0;
    for (int i = 0; i <= NCH; i++) sum += dly_tab[i];
    push_model(rm, r);
    wcnt = 0;
    @(negedge clk);
    cfg_ratiom = rm; cfg_ratio = r; cfg_req = 1'b1; pll_lock = 1'b0; t0 = cyc;
    @(negedge clk);
    cfg_req = 1'b0;
    chk("busy_on_accept", cfg_busy, 1);
    chk("err_clr_on_accept", cfg_err, 0);
    chk("rst_on_accept", pll_rst, 1);
    n = 0;
    while (pll_rst && n < 400) begin
      @(negedge clk);
      n++;
      // A request mid-sequence must be ignored.
      if (poke && n == 3) begin cfg_ratiom = rm ^ 7'h55; cfg_req = 1'b1; end
      else cfg_req = 1'b0;
    end
    tf = cyc;
    chk("rst_fall_seen", pll_rst, 0);
    chk("req_to_rst_fall", tf - t0, 1 + 2*(NCH+1) + sum + RST_CYC);
    chk("hold_after_last_wr", tf - last_wr_cyc - 1, RST_CYC);
    chk("all_words_written", exp_q.size(), 0);
    if (!lock_ok) begin
      n = 0;
      while (!cfg_err && n < TIMEOUT + 50) begin @(negedge clk); n++; end
      chk("lock_tmo_cycles", cyc - tf, TIMEOUT);
      chk("lock_tmo_code", err_code, 2'b01);
      chk("lock_tmo_busy", cfg_busy, 0);
      chk("lock_tmo_locked", locked, 0);
    end else begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      pll_lock = 1'b1; t1 = cyc; d0 = done_cnt;
      n = 0;
      while (!cfg_done && n < LOCK_STABLE + 50) begin @(negedge clk); n++; end
      chk("done_lat_window", (cyc - t1 >= 1 + LOCK_STABLE) && (cyc - t1 <= 3 + LOCK_STABLE), 1);
      chk("locked_at_done", locked, 1);
      chk("busy_drop_at_done", cfg_busy, 0);
      repeat (3) @(negedge clk);
      chk("done_one_pulse", done_cnt - d0, 1);
    end
  endtask

  initial begin
    int t0, n, g, h, l0, d0, ac;
    logic [6:0] rm;
    logic [8*NCH-1:0] r;
    foreach (dly_tab[i]) dly_tab[i] = 0;

    // Power-on: reset values, then qualify the boot configuration.
    repeat (3) @(negedge clk);
    chk_rst("por");
    rst_n = 1'b1; t0 = cyc;
    repeat (10) @(negedge clk);
    pll_lock = 1'b1;
    n = 0;
    while (!locked && n < 400) begin @(negedge clk); n++; end
    chk("por_lock_window", (cyc - t0 >= 10+2+LOCK_STABLE-1) && (cyc - t0 <= 10+2+LOCK_STABLE+1), 1);
    chk("por_no_done", done_cnt, 0);
    chk("por_busy", cfg_busy, 0);

    // Directed write sequence with zero channel divider.
    do_cfg(7'd20, {8'd5, 8'd0, 8'd9}, 1'b1, 1'b0);

    // Slow ready on word 1.
    dly_tab[1] = 3;
    do_cfg(7'($urandom), 24'($urandom), 1'b1, 1'b0);
    dly_tab[1] = 0;

    // Random requests with random ready stretching.
    for (int it = 0; it < 5; it++) begin
      for (int i = 0; i <= NCH; i++) dly_tab[i] = $urandom_range(0, 2);
      rm = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom);
      for (int i = 0; i < NCH; i++)
        r[8*i +: 8] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      do_cfg(rm, r, 1'b1, it[0]);
    end
    foreach (dly_tab[i]) dly_tab[i] = 0;

    // Lock glitches in RUN.
    l0 = lost_cnt; d0 = done_cnt;
    @(negedge clk); pll_lock = 1'b0;
    repeat (3) @(negedge clk);
    pll_lock = 1'b1;
    repeat (10) @(negedge clk);
    chk("glitch3_no_loss", lost_cnt - l0, 0);
    chk("glitch3_locked", locked, 1);
    pll_lock = 1'b0; g = cyc;
    repeat (4) @(negedge clk);
    pll_lock = 1'b1;
    n = 0;
    while (!lock_lost && n < 20) begin @(negedge clk); n++; end
    chk("loss_latency", cyc - g, 2 + LOSS_FILT);
    chk("loss_unlocked", locked, 0);
    pll_lock = 1'b0;
    h = 0;
    while (pll_rst && h < 100) begin h++; @(negedge clk); end
    chk("relock_rst_len", h, RST_CYC);
    pll_lock = 1'b1;
    n = 0;
    while (!locked && n < 400) begin @(negedge clk); n++; end
    chk("relock_locked", locked, 1);
    chk("relock_no_done", done_cnt - d0, 0);
    chk("relock_one_loss", lost_cnt - l0, 1);

    // APB ready never comes.
    stuck = 1'b1;
    push_model(7'd3, 24'h010203); wcnt = 0;
    @(negedge clk); cfg_ratiom = 7'd3; cfg_ratio = 24'h010203; cfg_req = 1'b1;
    @(negedge clk); cfg_req = 1'b0;
    n = 0; ac = 0;
    while (!cfg_err && n < TIMEOUT + 50) begin
      if (apb_en) ac++;
      @(negedge clk); n++;
    end
    chk("apb_tmo_access_cycles", ac, TIMEOUT);
    chk("apb_tmo_code", err_code, 2'b10);
    chk("apb_tmo_pll_rst", pll_rst, 1);
    chk("apb_tmo_sel_en", {apb_sel, apb_en}, 0);
    chk("apb_tmo_busy", cfg_busy, 0);
    exp_q.delete();
    stuck = 1'b0;

    // Restart from ERROR; lock never comes back.
    do_cfg(7'($urandom), 24'($urandom), 1'b0, 1'b0);
    // Restart again from lock-timeout ERROR and succeed.
    do_cfg(7'($urandom), 24'($urandom), 1'b1, 1'b0);

    // Reset during word 2 access.
    dly_tab[2] = 4;
    push_model(7'd7, 24'h332211); wcnt = 0; d0 = done_cnt;
    @(negedge clk); cfg_ratiom = 7'd7; cfg_ratio = 24'h332211; cfg_req = 1'b1; pll_lock = 1'b0;
    @(negedge clk); cfg_req = 1'b0;
    n = 0;
    while (!(wcnt == 2 && apb_en) && n < 60) begin @(negedge clk); n++; end
    chk("reached_word2", wcnt == 2 && apb_en, 1);
    #1 rst_n = 1'b0;
    #1 chk_rst("mid_rst");
    @(negedge clk);
    exp_q.delete(); wcnt = 0; dly_tab[2] = 0;
    pll_lock = 1'b1; rst_n = 1'b1; t0 = cyc;
    repeat (5) @(negedge clk);
    cfg_req = 1'b1;
    @(negedge clk); cfg_req = 1'b0;
    chk("waitlock_ignores_req", cfg_busy, 0);
    chk("waitlock_pll_rst", pll_rst, 0);
    n = 0;
    while (!locked && n < 400) begin @(negedge clk); n++; end
    chk("post_rst_lock_window", (cyc - t0 >= 2+LOCK_STABLE-1) && (cyc - t0 <= 2+LOCK_STABLE+1), 1);
    chk("post_rst_no_done", done_cnt - d0, 0);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
